inst_rom: RTL and testbench

Byte-addressed instruction memory on the responder side of the CPU fetch port. It answers the core's fetch address with a 6-byte instruction window in the same cycle. A byte-serial loader, driven by a small framing FSM, writes the program into the memory. It sits beside the core at top level: the core's ROM address output drives `rom_addr_i`, and `rom_data_o` drives the core's instruction input.

---
 rtl/inst_rom.sv | 126 ++++++++++++
 tb/tb_inst_rom.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom.sv
// inst_rom: byte-addressed instruction memory with a combinational 6-byte
// fetch window and a byte-serial, framed loader that writes the program.
module inst_rom #(
    parameter int DEPTH      = 1024,
    parameter int AW         = 32,
    parameter int INST_BYTES = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AW-1:0]           rom_addr_i,
    output logic [INST_BYTES*8-1:0] rom_data_o,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    output logic                    ld_ready,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    ld_err
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN_H,
        LEN_L,
        DATA,
        DONE
    } ldState_t;

    ldState_t       state;
    ldState_t       nextState;
    logic [7:0]     mem [DEPTH];
    logic [15:0]    baseAddr;
    logic [7:0]     lenHi;
    logic [IW-1:0]  ptr;
    logic [15:0]    count;
    logic           ldErrQ;
    logic           accept;
    logic           memWrite;
    logic [IW-1:0]  fetchIdx;

    // High address bits and base bits above the storage size are deliberately ignored
    logic unusedBits;
    assign unusedBits = ^{rom_addr_i[AW-1:IW], baseAddr[15:IW]};

    assign ld_ready = rst && (state != DONE);
    assign accept   = ld_valid && ld_ready;
    assign memWrite = accept && (state == DATA);
    assign ld_busy  = (state == ADDR_H) || (state == ADDR_L) || (state == LEN_H) ||
                      (state == LEN_L)  || (state == DATA);
    assign ld_done  = (state == DONE);
    assign ld_err   = ldErrQ;

    // Fetch window: byte i comes from (addr + i) wrapped to the storage size
    always_comb begin
        rom_data_o = '0;
        fetchIdx   = '0;
        for (int i = 0; i < INST_BYTES; i++) begin
            fetchIdx = rom_addr_i[IW-1:0] + IW'(i);
            rom_data_o[(INST_BYTES-1-i)*8 +: 8] = mem[fetchIdx];
        end
    end

    // Loader FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Loader FSM next-state: one transition per accepted byte, DONE lasts a single cycle
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept && ld_data == 8'hA5) nextState = ADDR_H;
            ADDR_H:  if (accept) nextState = ADDR_L;
            ADDR_L:  if (accept) nextState = LEN_H;
            LEN_H:   if (accept) nextState = LEN_L;
            LEN_L:   if (accept) nextState = ({lenHi, ld_data} == 16'd0) ? DONE : DATA;
            DATA:    if (accept && count == 16'd1) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Frame header capture, write pointer / remaining count, and bad-sync error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baseAddr <= '0;
            lenHi    <= '0;
            ptr      <= '0;
            count    <= '0;
            ldErrQ   <= 1'b0;
        end else begin
            ldErrQ <= accept && (state == IDLE) && (ld_data != 8'hA5);
            if (accept) begin
                case (state)
                    ADDR_H: baseAddr[15:8] <= ld_data;
                    ADDR_L: baseAddr[7:0]  <= ld_data;
                    LEN_H:  lenHi          <= ld_data;
                    LEN_L: begin
                        ptr   <= baseAddr[IW-1:0];
                        count <= {lenHi, ld_data};
                    end
                    DATA: begin
                        ptr   <= ptr + 1'b1;
                        count <= count - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage write; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem[ptr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: directed self-checking bench for inst_rom.
module tb_inst_rom;

    logic        clk;
    logic        rst;
    logic [31:0] romAddr;
    logic [47:0] romData;
    logic        ldValid;
    logic [7:0]  ldData;
    logic        ldReady;
    logic        ldBusy;
    logic        ldDone;
    logic        ldErr;

    int          vectors;
    int          miscompares;
    logic [7:0]  model [1024];
    logic [7:0]  payload [1024];

    inst_rom #(.DEPTH(1024), .AW(32), .INST_BYTES(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr_i(romAddr),
        .rom_data_o(romData),
        .ld_valid  (ldValid),
        .ld_data   (ldData),
        .ld_ready  (ldReady),
        .ld_busy   (ldBusy),
        .ld_done   (ldDone),
        .ld_err    (ldErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte with valid high for one clock edge; returns #1 after that edge
    task automatic applyStimulus(input logic [7:0] b);
        ldValid = 1'b1;
        ldData  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        ldValid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] expWindow(input int addr);
        logic [47:0] w;
        for (int i = 0; i < 6; i++) w[(5-i)*8 +: 8] = model[(addr + i) % 1024];
        return w;
    endfunction

    // Full frame from payload[]; checks done timing, busy and ready around DONE
    task automatic loadFrame(input string tag, input int base, input int len);
        int doneEarly;
        doneEarly = 0;
        applyStimulus(8'hA5);
        checkOutput({tag, "_busyAfterSync"}, {47'd0, ldBusy}, 48'd1);
        applyStimulus(8'(base >> 8));
        doneEarly += int'(ldDone);
        applyStimulus(8'(base));
        doneEarly += int'(ldDone);
        applyStimulus(8'(len >> 8));
        doneEarly += int'(ldDone);
        if (len == 0) begin
            applyStimulus(8'(len));
        end else begin
            applyStimulus(8'(len));
            doneEarly += int'(ldDone);
            for (int i = 0; i < len; i++) begin
                applyStimulus(payload[i]);
                model[(base + i) % 1024] = payload[i];
                if (i != len - 1) doneEarly += int'(ldDone);
            end
        end
        ldValid = 1'b0;
        checkOutput({tag, "_doneEarly"}, 48'(doneEarly), 48'd0);
        checkOutput({tag, "_doneOutputs"}, {45'd0, ldDone, ldReady, ldBusy}, {45'd0, 3'b100});
        idleCycle();
        checkOutput({tag, "_afterDone"}, {45'd0, ldDone, ldReady, ldBusy}, {45'd0, 3'b010});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        ldValid     = 1'b0;
        ldData      = 8'h00;
        romAddr     = 32'd0;

        // Reset state
        #12;
        checkOutput("resetOutputs", {44'd0, ldReady, ldBusy, ldDone, ldErr}, 48'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("readyAfterReset", {47'd0, ldReady}, 48'd1);
        @(posedge clk);
        #1;

        // Fill the whole memory with a known pattern (length 0x0400 > 256)
        for (int i = 0; i < 1024; i++) payload[i] = 8'(i * 7 + 3);
        loadFrame("init", 0, 1024);
        romAddr = 32'h0000_0013;
        #1;
        checkOutput("initFetch13", romData, 48'h888F969DA4AB);

        // Program load and fetch at 0x10
        payload[0] = 8'h30; payload[1] = 8'hF0; payload[2] = 8'h05;
        loadFrame("prog", 16'h0010, 3);
        romAddr = 32'h0000_0010;
        #1;
        checkOutput("fetch10", romData, 48'h30F005888F96);
        romAddr = 32'hFFFF_FC10;
        #1;
        checkOutput("fetchHighBitsIgnored", romData, 48'h30F005888F96);

        // Load across the top of memory
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        payload[3] = 8'h44; payload[4] = 8'h55; payload[5] = 8'h66;
        loadFrame("wrap", 16'h03FE, 6);
        romAddr = 32'h0000_03FE;
        #1;
        checkOutput("fetch3FE", romData, 48'h112233445566);
        romAddr = 32'h0000_03FF;
        #1;
        checkOutput("fetch3FF", romData, 48'h223344556600 | 48'h1F);
        romAddr = 32'h0000_0000;
        #1;
        checkOutput("fetch000", romData, 48'h334455661F26);

        // Bad sync bytes in IDLE
        applyStimulus(8'h00);
        checkOutput("err1", {46'd0, ldErr, ldBusy}, {46'd0, 2'b10});
        applyStimulus(8'h12);
        checkOutput("err2", {46'd0, ldErr, ldBusy}, {46'd0, 2'b10});
        idleCycle();
        checkOutput("errCleared", {46'd0, ldErr, ldBusy}, 48'd0);
        romAddr = 32'h0000_0010;
        #1;
        checkOutput("memAfterErr", romData, 48'h30F005888F96);

        // Zero-length frame
        loadFrame("len0", 16'h0020, 0);
        romAddr = 32'h0000_0020;
        #1;
        checkOutput("memAfterLen0", romData, expWindow(32'h20));

        // Reset after 2 of 4 data bytes
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h40);
        applyStimulus(8'h00);
        applyStimulus(8'h04);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        ldValid = 1'b0;
        rst     = 1'b0;
        #1;
        checkOutput("midReset", {45'd0, ldReady, ldBusy, ldDone}, 48'd0);
        @(posedge clk);
        #1;
        checkOutput("midResetHold", {46'd0, ldBusy, ldDone}, 48'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postResetIdle", {45'd0, ldReady, ldBusy, ldDone}, {45'd0, 3'b100});
        applyStimulus(8'h77);
        checkOutput("postResetErr", {46'd0, ldErr, ldBusy}, {46'd0, 2'b10});
        ldValid = 1'b0;
        romAddr = 32'h0000_0040;
        #1;
        checkOutput("partialFrame", romData, 48'hAABBD1D8DFE6);

        // Valid gap in DATA, with a same-cycle fetch/write of byte 0x83
        applyStimulus(8'hA5);
        applyStimulus(8'h00);
        applyStimulus(8'h80);
        applyStimulus(8'h00);
        applyStimulus(8'h04);
        applyStimulus(8'hC1);
        applyStimulus(8'hC2);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkOutput("gapHold", {45'd0, ldReady, ldBusy, ldDone}, {45'd0, 3'b110});
        end
        applyStimulus(8'hC3);
        checkOutput("gapNotDone", {46'd0, ldBusy, ldDone}, {46'd0, 2'b10});
        ldValid = 1'b1;
        ldData  = 8'hC4;
        romAddr = 32'h0000_0083;
        #1;
        checkOutput("oldBeforeEdge", {40'd0, romData[47:40]}, 48'h98);
        @(posedge clk);
        #1;
        ldValid = 1'b0;
        checkOutput("newAfterEdge", {40'd0, romData[47:40]}, 48'hC4);
        checkOutput("gapDone", {46'd0, ldDone, ldBusy}, {46'd0, 2'b10});
        idleCycle();
        checkOutput("gapDoneOnce", {47'd0, ldDone}, 48'd0);
        romAddr = 32'h0000_0080;
        #1;
        checkOutput("gapContents", romData, 48'hC1C2C3C49FA6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
